// File: rtl/reimu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reimu_pkg : shared widths, playfield limits and FSM encoding for the  |
// |             player shot engine.                    Revision: 1.0     |
// +----------------------------------------------------------------------+
package reimu_pkg;
    localparam int POS_W = 10;
    localparam int HP_W  = 8;
    localparam int X_MIN = 8;
    localparam int X_MAX = 432;
    localparam int Y_MIN = 8;
    localparam int Y_MAX = 472;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIGHT    = 2'd1,
        ST_DEFEATED = 2'd2
    } state_e;
endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bullet_slot : one player bullet; load, upward move, top-border bound |
// |               and boss hitbox test.                Revision: 1.0     |
// +----------------------------------------------------------------------+
module bullet_slot
    import reimu_pkg::*;
#(
    parameter int SPEED  = 12,
    parameter int HALF_W = 32,
    parameter int HALF_H = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_active,
    input  logic             i_load,
    input  logic [POS_W-1:0] i_load_x,
    input  logic [POS_W-1:0] i_load_y,
    input  logic [POS_W-1:0] i_bossx,
    input  logic [POS_W-1:0] i_bossy,
    output logic             o_valid,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y,
    output logic             o_hit
);
    typedef logic [POS_W:0] ext_t;

    localparam ext_t             c_HALF_W = ext_t'(HALF_W);
    localparam ext_t             c_HALF_H = ext_t'(HALF_H);
    localparam logic [POS_W-1:0] c_TOP    = POS_W'(Y_MIN + SPEED);
    localparam logic [POS_W-1:0] c_SPEED  = POS_W'(SPEED);

    logic             valid_q, valid_d;
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             w_overlap;

    // One extra bit keeps the hitbox sums from wrapping near the edges.
    assign w_overlap = ({1'b0, x_q} + c_HALF_W > {1'b0, i_bossx}) &&
                       ({1'b0, x_q} < {1'b0, i_bossx} + c_HALF_W) &&
                       ({1'b0, y_q} + c_HALF_H > {1'b0, i_bossy}) &&
                       ({1'b0, y_q} < {1'b0, i_bossy} + c_HALF_H);

    assign o_hit = i_active && valid_q && w_overlap;

    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        if (i_flush) begin
            valid_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end else if (i_active && valid_q) begin
            if (w_overlap || (y_q < c_TOP)) begin
                valid_d = 1'b0;
                x_d     = '0;
                y_d     = '0;
            end else begin
                y_d = y_q - c_SPEED;
            end
        end else if (i_load) begin
            valid_d = 1'b1;
            x_d     = i_load_x;
            y_d     = i_load_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign o_valid = valid_q;
    assign o_x     = x_q;
    assign o_y     = y_q;
endmodule
`default_nettype wire

// File: rtl/reimu_bullet.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reimu_bullet : player shot engine; slot pool, fire cooldown, boss HP |
// |                bookkeeping and fight FSM.          Revision: 1.0     |
// +----------------------------------------------------------------------+
module reimu_bullet
    import reimu_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SPEED     = 12,
    parameter int COOLDOWN  = 3,
    parameter int HP_INIT   = 100,
    parameter int DAMAGE    = 1,
    parameter int HALF_W    = 32,
    parameter int HALF_H    = 32,
    parameter int MUZZLE_DY = 16
) (
    input  logic                       clk22,
    input  logic                       rst_n,
    input  logic                       gamestart,
    input  logic                       boss,
    input  logic                       fire,
    input  logic [POS_W-1:0]           reimux,
    input  logic [POS_W-1:0]           reimuy,
    input  logic [POS_W-1:0]           bossx,
    input  logic [POS_W-1:0]           bossy,
    output logic [NUM_SLOTS-1:0]       bullet_valid,
    output logic [POS_W*NUM_SLOTS-1:0] bulletx,
    output logic [POS_W*NUM_SLOTS-1:0] bullety,
    output logic                       boss_hit,
    output logic [HP_W-1:0]            boss_hp,
    output logic                       boss_defeated
);
    localparam int CD_W   = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam int HITS_W = $clog2(NUM_SLOTS + 1);

    state_e                 state_q, state_d;
    logic [CD_W-1:0]        cd_q, cd_d;
    logic [HP_W-1:0]        hp_q, hp_d;
    logic                   hit_q, hit_d;
    logic                   defeated_q, defeated_d;

    logic                   w_active;
    logic                   w_flush;
    logic                   w_fire;
    logic                   w_found;
    logic [NUM_SLOTS-1:0]   w_valid;
    logic [NUM_SLOTS-1:0]   w_hit;
    logic [NUM_SLOTS-1:0]   w_load;
    logic [HITS_W-1:0]      w_hits;
    logic [15:0]            w_dmg;
    logic [POS_W-1:0]       w_spawn_y;

    // Slots only act while fighting with the boss present; everywhere else they are held clear.
    assign w_active  = (state_q == ST_FIGHT) && boss;
    assign w_flush   = !w_active || gamestart;
    assign w_fire    = w_active && fire && (cd_q == '0) && !(&w_valid);
    assign w_spawn_y = (reimuy >= POS_W'(MUZZLE_DY)) ? (reimuy - POS_W'(MUZZLE_DY)) : '0;

    always_comb begin
        w_load  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_valid[i] && !w_found) begin
                w_load[i] = w_fire;
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        w_hits = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_hits = w_hits + HITS_W'(w_hit[i]);
        end
        w_dmg = 16'(w_hits) * 16'(DAMAGE);
    end

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            bullet_slot #(
                .SPEED  (SPEED),
                .HALF_W (HALF_W),
                .HALF_H (HALF_H)
            ) u_slot (
                .clk      (clk22),
                .rst_n    (rst_n),
                .i_flush  (w_flush),
                .i_active (w_active),
                .i_load   (w_load[i]),
                .i_load_x (reimux),
                .i_load_y (w_spawn_y),
                .i_bossx  (bossx),
                .i_bossy  (bossy),
                .o_valid  (w_valid[i]),
                .o_x      (bulletx[POS_W*i +: POS_W]),
                .o_y      (bullety[POS_W*i +: POS_W]),
                .o_hit    (w_hit[i])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        hit_d      = 1'b0;
        defeated_d = defeated_q;
        cd_d       = (cd_q != '0) ? (cd_q - CD_W'(1)) : '0;
        case (state_q)
            ST_IDLE: begin
                if (boss) state_d = ST_FIGHT;
            end
            ST_FIGHT: begin
                if (!boss) begin
                    state_d = ST_IDLE;
                end else begin
                    if (w_fire) cd_d = CD_W'(COOLDOWN);
                    hit_d = |w_hit;
                    hp_d  = (w_dmg >= {8'd0, hp_q}) ? '0 : (hp_q - w_dmg[HP_W-1:0]);
                    if (hp_d == '0) begin
                        state_d    = ST_DEFEATED;
                        defeated_d = 1'b1;
                    end
                end
            end
            ST_DEFEATED: begin
                state_d = ST_DEFEATED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk22) begin
        if (!rst_n || gamestart) begin
            state_q    <= ST_IDLE;
            cd_q       <= '0;
            hp_q       <= HP_W'(HP_INIT);
            hit_q      <= 1'b0;
            defeated_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cd_q       <= cd_d;
            hp_q       <= hp_d;
            hit_q      <= hit_d;
            defeated_q <= defeated_d;
        end
    end

    assign bullet_valid  = w_valid;
    assign boss_hit      = hit_q;
    assign boss_hp       = hp_q;
    assign boss_defeated = defeated_q;
endmodule
`default_nettype wire

// File: doc/reimu_bullet.md
Name: reimu_bullet

Overview:
- Player-side shot engine; the counterpart of the boss shot logic. Reimu fires upward, and this block detects hits on the boss rather than on Reimu.
- Owns a small pool of player bullets, a fire cooldown, and boss hit-point bookkeeping.
- Feeds the VGA sprite mux (bullet positions and valid bits) and the game-flow controller (boss_hit, boss_hp, boss_defeated).
- Runs on the same game tick clock as all sprite logic.

Parameters:
- NUM_SLOTS, 4: number of simultaneous player bullets.
- SPEED, 12: upward pixels per tick.
- COOLDOWN, 3: ticks between accepted shots.
- HP_INIT, 100: boss hit points at fight start (8-bit).
- DAMAGE, 1: HP removed per hit.
- HALF_W, 32: boss hitbox half-width in pixels.
- HALF_H, 32: boss hitbox half-height in pixels.
- MUZZLE_DY, 16: spawn offset above reimuy.

Ports:
- clk22, in, 1: game tick clock. All state is updated on its rising edge.
- rst_n, in, 1: reset. One clock; reset is synchronous and active-low.
- gamestart, in, 1: synchronous clear, same effect as reset.
- boss, in, 1: boss phase active.
- fire, in, 1: shoot button, level-sensitive.
- reimux, in, 10: player centre x.
- reimuy, in, 10: player centre y.
- bossx, in, 10: boss centre x.
- bossy, in, 10: boss centre y.
- bullet_valid, out, NUM_SLOTS: per-slot "bullet exists".
- bulletx, out, 10*NUM_SLOTS: packed slot x positions; slot i occupies bits [10i+9:10i].
- bullety, out, 10*NUM_SLOTS: packed slot y positions, same packing.
- boss_hit, out, 1: one-tick pulse when at least one bullet hit this tick.
- boss_hp, out, 8: remaining boss HP.
- boss_defeated, out, 1: sticky flag, set when HP reaches 0.

Behaviour:
- Clear condition: !rst_n or gamestart.
  - Forces all bullet_valid, bulletx and bullety to 0.
  - boss_hit=0, boss_defeated=0, boss_hp=HP_INIT, cooldown=0, state=IDLE.
- FSM states IDLE, FIGHT, DEFEATED.
  - IDLE -> FIGHT when boss=1.
  - FIGHT -> IDLE when boss=0. All slots are cleared; HP and cooldown are kept.
  - FIGHT -> DEFEATED when next HP computes to 0.
  - DEFEATED is left only via the clear condition.
- IDLE: slots invalid, fire ignored, boss_hit=0.
- Per slot, FIGHT only, one decision per tick. Priority is hit > out-of-range > move.
  - Hit: valid and (bulletx+HALF_W > bossx) and (bulletx < bossx+HALF_W) and (bullety+HALF_H > bossy) and (bullety < bossy+HALF_H).
    - All four compares are evaluated 11 bits wide, so there is no wrap near 0.
    - On hit: valid->0 and x,y->0.
  - Out-of-range: valid and bullety < 8+SPEED, which would cross the top border. Then valid->0 and x,y->0.
  - Move: otherwise a valid slot updates bullety -= SPEED; x is unchanged.
- Firing, FIGHT only:
  - Condition: fire=1, cooldown=0, and some slot is invalid at the start of the tick.
  - Load target: lowest-index invalid slot.
  - Loaded values: valid=1, x=reimux, y = reimuy - MUZZLE_DY, saturated to 0.
  - Cooldown reloads to COOLDOWN.
  - A slot freed in the same tick is not reused until the next tick.
  - A newly loaded bullet is neither moved nor hit-checked until the following tick.
- Cooldown: decrements by 1 per tick while nonzero and saturates at 0. It also counts down in IDLE.
- Latency:
  - fire sampled at edge t gives bullet_valid=1 after edge t, i.e. visible at t+1.
  - A hit computed in tick t clears the slot and pulses boss_hit after the same edge, for exactly one tick.
- HP:
  - Hits in one tick: hits = popcount of hit flags. Damage = hits*DAMAGE.
  - boss_hp = max(0, boss_hp - damage), using a saturating 8-bit subtract.
  - Multiple simultaneous hits are all counted.
- Defeat:
  - When HP becomes 0: boss_defeated=1 on the same edge, and all slots are cleared on the following edge.
  - In DEFEATED, fire is ignored and boss_hit stays 0.
- A reset or gamestart assertion mid-flight clears everything on the next edge, regardless of state.

Decomposition:
- Shared package reimu_pkg holds:
  - POS_W=10.
  - Playfield limits: X_MIN=8, X_MAX=432, Y_MIN=8, Y_MAX=472.
  - FSM state typedef (IDLE/FIGHT/DEFEATED), 2-bit.
  - HP width 8.
- Sub-module bullet_slot, instantiated NUM_SLOTS times. It holds:
  - valid, x, y registers.
  - Load port, plus move, bound and hit logic.
  - A hit flag output.
- The top level holds the free-slot allocator (priority encoder), cooldown counter, popcount/HP update and FSM.

Test Plan:
- Reset release with boss=1, fire=1 held, COOLDOWN=3, reimux=200, reimuy=400:
  - Slot0 valid at tick 1 with (200,384).
  - Slot1 loads at tick 5.
  - Slot0 y is 372 at tick 2.
- Bullet at (200,60) with boss at (200,40) -> boss_hit pulses 1 tick, boss_hp 100->99, slot0 invalid.
- Two bullets entering the hitbox in the same tick -> boss_hp drops by 2, single boss_hit pulse.
- Bullet y=15 with no boss overlap -> slot freed next tick, boss_hp unchanged. Bullet spawning at reimuy=10 saturates to y=0 and is freed at its first move.
- Set HP=1 via HP_INIT=1, then hit -> boss_hp=0, boss_defeated=1 sticky. Subsequent fire produces no bullets until gamestart, after which boss_hp=1 and the flag is 0.
- Mid-flight, boss drops to 0 -> all valid bits 0 next tick. rst_n=0 while slots are active -> all outputs at reset values next edge.
